// File: rtl/ppu_palette_cache.sv
// ppu_palette_cache: on a start pulse, reloads a cached copy of the PPU palette from VRAM.
// It streams one read per entry and captures each returning byte into a flat register array.
// Latency: start-to-done is NUM_ENTRIES + RD_LAT cycles. A start received while busy is dropped.
// No backpressure exists: the VRAM port must return data exactly RD_LAT cycles after each strobe.
// Optional feature macro: PPU_PALETTE_SNOOP_EN adds the CPU palette-write snoop path.
//
// Ports:
//   clk, rst          sole clock; synchronous active-high reset
//   start             one-cycle reload request (ignored while busy)
//   busy, done        load in progress; one-cycle pulse after the last entry is written
//   vram_addr/rd_en   fetch address and strobe (address rests at BASE_ADDR when idle)
//   vram_data_in      fetch data, valid RD_LAT cycles after the strobe
//   snoop_*           CPU palette-write observation port (used only with the macro)
//   palette_flat      entry i is at bits [i*ENTRY_W +: ENTRY_W], straight from flops
module ppu_palette_cache #(
  parameter int          NUM_ENTRIES     = 32,
  parameter int          ENTRY_W         = 8,
  parameter logic [15:0] BASE_ADDR       = 16'h3F00,
  parameter int          RD_LAT          = 1,
  parameter int          BACKDROP_MIRROR = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    vram_addr,
  output logic                           vram_rd_en,
  input  logic [7:0]                     vram_data_in,
  input  logic                           snoop_we,
  input  logic [15:0]                    snoop_addr,
  input  logic [7:0]                     snoop_data,
  output logic [NUM_ENTRIES*ENTRY_W-1:0] palette_flat
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam int PAL_W = NUM_ENTRIES * ENTRY_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic [15:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic [RD_LAT-1:0]  vld_q, vld_d;
  logic [PAL_W-1:0]   pal_q, pal_d;

  logic               capture;

  // Entries with index[1:0]==0 all alias the universal backdrop colour at BASE_ADDR.
  function automatic logic [15:0] fetch_addr(input logic [CNT_W-1:0] k);
    if (BACKDROP_MIRROR == 1 && k[1:0] == 2'b00) begin
      return BASE_ADDR;
    end
    return BASE_ADDR + 16'(k);
  endfunction

  // The head of the valid pipe marks the cycle in which vram_data_in belongs
  // to the entry currently pointed to by the capture counter.
  assign capture = vld_q[RD_LAT-1];

`ifdef PPU_PALETTE_SNOOP_EN
  logic [15:0] snoop_off;
  logic        snoop_hit;
  logic        snoop_bcast;

  assign snoop_off   = snoop_addr - BASE_ADDR;
  // The lower bound is checked explicitly so that addresses below BASE_ADDR,
  // which wrap to large offsets, can never alias onto a low entry.
  assign snoop_hit   = snoop_we && (snoop_addr >= BASE_ADDR) &&
                       (snoop_off < 16'(NUM_ENTRIES));
  assign snoop_bcast = (BACKDROP_MIRROR == 1) && (snoop_off[1:0] == 2'b00);
`else
  // The snoop port has no function in this build; this sink keeps the port list stable.
  logic unused_snoop;
  assign unused_snoop = ^{snoop_we, snoop_addr, snoop_data};
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = rd_en_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    pal_d       = pal_q;

    // The strobe history shifts one stage per cycle.
    vld_d[0] = rd_en_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    if (capture) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (cap_cnt_q[IDX_W-1:0] == i[IDX_W-1:0]) begin
          pal_d[i*ENTRY_W +: ENTRY_W] = vram_data_in[ENTRY_W-1:0];
        end
      end
      cap_cnt_d = cap_cnt_q + CNT_W'(1);
      if (cap_cnt_q == CNT_W'(NUM_ENTRIES - 1)) begin
        done_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        rd_en_d = 1'b0;
        addr_d  = BASE_ADDR;
        if (start) begin
          // Entry 0 is issued on the accepting edge, so the counters restart
          // at "one issued, none captured".
          state_d     = ISSUE;
          busy_d      = 1'b1;
          rd_en_d     = 1'b1;
          addr_d      = fetch_addr('0);
          issue_cnt_d = CNT_W'(1);
          cap_cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (issue_cnt_q == CNT_W'(NUM_ENTRIES)) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
          addr_d  = BASE_ADDR;
        end else begin
          rd_en_d     = 1'b1;
          addr_d      = fetch_addr(issue_cnt_q);
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        // The final capture always falls in DRAIN. busy stays high through
        // the done cycle and drops one cycle later.
        if (done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        addr_d      = BASE_ADDR;
        issue_cnt_d = '0;
        cap_cnt_d   = '0;
        vld_d       = '0;
        pal_d       = '0;
      end
    endcase

`ifdef PPU_PALETTE_SNOOP_EN
    // This block runs last, so a CPU write overrides a capture to the same entry on the same edge.
    if (snoop_hit) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (snoop_bcast ? (i[1:0] == 2'b00)
                        : (snoop_off[IDX_W-1:0] == i[IDX_W-1:0])) begin
          pal_d[i*ENTRY_W +: ENTRY_W] = snoop_data[ENTRY_W-1:0];
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= BASE_ADDR;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      vld_q       <= '0;
      pal_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      vld_q       <= vld_d;
      pal_q       <= pal_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign vram_rd_en   = rd_en_q;
  assign vram_addr    = addr_q;
  assign palette_flat = pal_q;

endmodule

// File: doc/ppu_palette_cache.md
PPU_PALETTE_CACHE -- requirements
Module: ppu_palette_cache

Interface
REQ-001 Parameter NUM_ENTRIES, default 32: palette entries cached; power of two, 4..64.
REQ-002 Parameter ENTRY_W, default 8: bits stored per entry, taken from vram_data_in[ENTRY_W-1:0]; range 1..8.
REQ-003 Parameter BASE_ADDR, default 16'h3F00: VRAM address of entry 0.
REQ-004 Parameter RD_LAT, default 1: cycles from vram_rd_en/vram_addr to valid vram_data_in; range 1..4.
REQ-005 Parameter BACKDROP_MIRROR, default 1: when 1, every entry whose index[1:0]==0 is fetched from BASE_ADDR.
REQ-006 clk  input  1  sole clock; all logic on posedge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to reload the whole palette.
REQ-009 busy  output  1  high while a load is in progress.
REQ-010 done  output  1  one-cycle pulse on the cycle the last entry is written.
REQ-011 vram_addr  output  16  fetch address.
REQ-012 vram_rd_en  output  1  fetch strobe; vram_addr is valid when this is high.
REQ-013 vram_data_in  input  8  fetch data, valid RD_LAT cycles after the strobe.
REQ-014 snoop_we, snoop_addr[15:0], snoop_data[7:0]  input  CPU palette-write observation port.
REQ-015 palette_flat  output  NUM_ENTRIES*ENTRY_W  entry i is at bits [i*ENTRY_W +: ENTRY_W].

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE and DRAIN; any illegal encoding SHALL return to IDLE with the reset values.
REQ-017 In IDLE, start=1 SHALL zero the issue and capture counters, raise busy on the next cycle and enter ISSUE.
REQ-018 start while busy SHALL be ignored; a load cannot be restarted or queued.
REQ-019 ISSUE SHALL assert vram_rd_en for exactly NUM_ENTRIES consecutive cycles, one per index k = 0..NUM_ENTRIES-1, then enter DRAIN.
REQ-020 The issued address SHALL be BASE_ADDR when BACKDROP_MIRROR=1 and k[1:0]==0; otherwise it SHALL be BASE_ADDR+k (16-bit, wrap-around allowed).
REQ-021 A shift-register valid pipe of depth RD_LAT SHALL capture vram_data_in into entry k exactly RD_LAT cycles after k was issued.
REQ-022 The cycle that captures entry NUM_ENTRIES-1 SHALL pulse done, and busy SHALL drop on the following cycle (state IDLE).
REQ-023 The total start-to-done time SHALL be NUM_ENTRIES+RD_LAT cycles; the defaults give 33.
REQ-024 When vram_rd_en=0, vram_addr SHALL hold BASE_ADDR.
REQ-025 palette_flat SHALL be a direct register output with no combinational path from any input.
REQ-026 Entries not yet captured during a load SHALL keep their previous values.

Reset
REQ-027 rst=1 on a clock edge SHALL set the state to IDLE, busy=0, done=0, vram_rd_en=0, vram_addr=BASE_ADDR, clear both counters and the valid pipe, and zero palette_flat.
REQ-028 rst during a load SHALL abort it; data returning after the reset edge SHALL be discarded.

Configuration
REQ-029 With the macro PPU_PALETTE_SNOOP_EN defined, the snoop path below SHALL be compiled in.
REQ-030 When snoop_we=1 and BASE_ADDR <= snoop_addr < BASE_ADDR+NUM_ENTRIES, the block SHALL compute j = snoop_addr-BASE_ADDR and update the entry on the next edge.
REQ-031 If BACKDROP_MIRROR=1 and j[1:0]==0, that snoop write SHALL update every entry whose index[1:0]==0; otherwise it SHALL update entry j only.
REQ-032 Snoop writes SHALL be accepted in any state.
REQ-033 If a snoop write and a load capture hit the same entry on the same edge, the snoop value SHALL win.
REQ-034 Without PPU_PALETTE_SNOOP_EN, the snoop ports SHALL remain present and SHALL be ignored, with no logic behind them.

Verification
REQ-035 Scenario: defaults, VRAM model 3F00+k holds 8'h40+k, pulse start -> entry 0 = 8'h40, entry 1 = 8'h41, entry 4 = 8'h40, entry 31 = 8'h5F; done pulses 33 cycles after start.
REQ-036 Scenario: RD_LAT=3, NUM_ENTRIES=16, ENTRY_W=6, data 8'hFF -> all entries 6'h3F; done pulses 19 cycles after start; vram_rd_en is high for exactly 16 cycles.
REQ-037 Scenario: start re-pulsed at cycle 10 of a load -> no restart; a single done pulse at cycle 33.
REQ-038 Scenario: rst at cycle 12 of a load -> the next cycle shows busy=0, palette_flat=0; no done pulse ever follows.
REQ-039 Scenario: snoop enabled, idle, snoop_we with 3F10 and 8'h2A -> entries 0, 4, 8 .. 28 all 8'h2A; 3F05 with 8'h11 -> only entry 5 changes; 3F20 -> no change.
REQ-040 Scenario: snoop enabled, a snoop to 3F07 on the same edge as the capture of entry 7 -> entry 7 holds the snoop data.
